// File: rtl/kbd_uart_receiver.sv
// kbd_uart_receiver
//   Serial keyboard front end. Receives UART frames on IN_SERIAL_RX and stores
//   the bytes in a small FIFO. Each byte is handed to the interrupt controller
//   through an irq/iack/iend handshake and is presented on kbd.
//
//   Optional build macro: KBD_PARITY_EN
//     undefined -> 8N1 frames (default)
//     defined   -> 8E1 frames; a byte with bad parity is discarded at STOP
//
// Ports
//   CLK           system clock, all state changes on the rising edge
//   RESET         synchronous, active-high reset
//   IN_SERIAL_RX  asynchronous UART line, idle high
//   kbd[7:0]      byte delivered by the last accepted iack
//   irq           interrupt request to the interrupt controller
//   iack          interrupt acknowledge, single-cycle pulse
//   iend          end of interrupt service, single-cycle pulse
//   overrun       sticky flag: at least one byte was dropped on a full FIFO
module kbd_uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_SERIAL_RX,
  output logic [7:0] kbd,
  output logic       irq,
  input  logic       iack,
  input  logic       iend,
  output logic       overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef KBD_PARITY_EN
  typedef enum logic [2:0] {HUNT, IDLE, START, DATA, PARITY, STOP} rxState_t;
`else
  typedef enum logic [2:0] {HUNT, IDLE, START, DATA, STOP} rxState_t;
`endif
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_SERVICE} intState_t;

  rxState_t         r_rxState, w_rxNext;
  intState_t        r_intState, w_intNext;
  logic             r_rxMeta, r_rxS;
  logic [CNT_W-1:0] r_sampleCnt;
  logic [2:0]       r_bitCnt;
  logic [7:0]       r_shiftReg;
  logic [7:0]       r_fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr, r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_kbd;
  logic             r_overrun;
`ifdef KBD_PARITY_EN
  logic             r_parityBad;
  logic             w_parityEn;
`endif

  logic w_bitEnd, w_cntClear, w_shiftEn, w_pushReq;
  logic w_fifoFull, w_fifoEmpty, w_pop, w_pushOk, w_drop, w_iendOk;

  assign w_bitEnd    = (r_sampleCnt == BIT_LAST);
  assign w_fifoFull  = (r_count == FULL_COUNT);
  assign w_fifoEmpty = (r_count == '0);
  // A pop can only happen in I_REQ, which is entered only with data present.
  assign w_pop    = (r_intState == I_REQ) && iack;
  assign w_pushOk = w_pushReq && (!w_fifoFull || w_pop);
  assign w_drop   = w_pushReq && w_fifoFull && !w_pop;
  assign kbd      = r_kbd;
  assign overrun  = r_overrun;

  // Two-flop synchroniser; held at the idle level during reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
    end else begin
      r_rxMeta <= IN_SERIAL_RX;
      r_rxS    <= r_rxMeta;
    end
  end

  // Receiver state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_rxState <= HUNT;
    else       r_rxState <= w_rxNext;
  end

  // Receiver next state. HUNT waits for a full bit time of idle line so a
  // reset in the middle of a frame cannot lock onto a data bit as a start.
  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      HUNT:   if (r_rxS && w_bitEnd) w_rxNext = IDLE;
      IDLE:   if (!r_rxS) w_rxNext = START;
      START:  if (r_sampleCnt == HALF_BIT) w_rxNext = r_rxS ? IDLE : DATA;
`ifdef KBD_PARITY_EN
      DATA:   if (w_bitEnd && r_bitCnt == 3'd7) w_rxNext = PARITY;
      PARITY: if (w_bitEnd) w_rxNext = STOP;
`else
      DATA:   if (w_bitEnd && r_bitCnt == 3'd7) w_rxNext = STOP;
`endif
      STOP:   if (w_bitEnd) w_rxNext = r_rxS ? IDLE : HUNT;
      default: w_rxNext = HUNT;
    endcase
  end

  // Receiver control outputs. The counter restarts whenever a sample point
  // is reached, so DATA/STOP samples land one bit time after the previous one.
  always_comb begin
    w_cntClear = 1'b0;
    w_shiftEn  = 1'b0;
    w_pushReq  = 1'b0;
`ifdef KBD_PARITY_EN
    w_parityEn = 1'b0;
`endif
    case (r_rxState)
      HUNT:   w_cntClear = !r_rxS;
      IDLE:   w_cntClear = 1'b1;
      START:  w_cntClear = (r_sampleCnt == HALF_BIT);
      DATA: begin
        w_cntClear = w_bitEnd;
        w_shiftEn  = w_bitEnd;
      end
`ifdef KBD_PARITY_EN
      PARITY: begin
        w_cntClear = w_bitEnd;
        w_parityEn = w_bitEnd;
      end
      STOP: begin
        w_cntClear = w_bitEnd;
        w_pushReq  = w_bitEnd && r_rxS && !r_parityBad;
      end
`else
      STOP: begin
        w_cntClear = w_bitEnd;
        w_pushReq  = w_bitEnd && r_rxS;
      end
`endif
      default: w_cntClear = 1'b1;
    endcase
  end

  // Receiver datapath: sample counter, bit counter and LSB-first shifter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sampleCnt <= '0;
      r_bitCnt    <= '0;
      r_shiftReg  <= '0;
`ifdef KBD_PARITY_EN
      r_parityBad <= 1'b0;
`endif
    end else begin
      r_sampleCnt <= w_cntClear ? '0 : r_sampleCnt + 1'b1;
      if (r_rxState == IDLE) begin
        r_bitCnt <= '0;
`ifdef KBD_PARITY_EN
        r_parityBad <= 1'b0;
`endif
      end
      if (w_shiftEn) begin
        r_shiftReg <= {r_rxS, r_shiftReg[7:1]};
        r_bitCnt   <= r_bitCnt + 1'b1;
      end
`ifdef KBD_PARITY_EN
      // Even parity: data bits plus parity bit must XOR to zero.
      if (w_parityEn) r_parityBad <= ^{r_shiftReg, r_rxS};
`endif
    end
  end

  // FIFO storage. When full with a simultaneous pop, write and read hit the
  // same slot; the read still returns the old byte.
  always_ff @(posedge CLK) begin
    if (w_pushOk) r_fifoMem[r_wrPtr] <= r_shiftReg;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Interrupt handshake state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_intState <= I_IDLE;
    else       r_intState <= w_intNext;
  end

  // Interrupt next state. iend is only looked at in I_SERVICE, so an iend
  // arriving together with iack in I_REQ has no effect.
  always_comb begin
    w_intNext = r_intState;
    case (r_intState)
      I_IDLE:    if (!w_fifoEmpty) w_intNext = I_REQ;
      I_REQ:     if (iack) w_intNext = I_SERVICE;
      I_SERVICE: if (iend) w_intNext = I_IDLE;
      default:   w_intNext = I_IDLE;
    endcase
  end

  // Interrupt outputs.
  always_comb begin
    irq      = (r_intState == I_REQ);
    w_iendOk = (r_intState == I_SERVICE) && iend;
  end

  // Delivered byte and sticky overrun; a drop in the clearing cycle wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_kbd     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pop) r_kbd <= r_fifoMem[r_rdPtr];
      if (w_drop)        r_overrun <= 1'b1;
      else if (w_iendOk) r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kbd_uart_receiver.sv
// tb_kbd_uart_receiver
//   Directed bench for kbd_uart_receiver with CLKS_PER_BIT=16, FIFO_DEPTH=4.
//   Inputs are driven on the falling clock edge; outputs are read there too.
module tb_kbd_uart_receiver;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IN_SERIAL_RX;
  logic [7:0] kbd;
  logic       irq;
  logic       iack;
  logic       iend;
  logic       overrun;

  int compared       = 0;
  int mismatched     = 0;
  int cycleCount     = 0;
  int irqRiseCycle   = 0;
  int lastStartCycle = 0;
  logic prevIrq      = 1'b0;
`ifdef KBD_PARITY_EN
  logic tbParityFlip = 1'b0;
`endif

  kbd_uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .IN_SERIAL_RX(IN_SERIAL_RX), .kbd(kbd),
    .irq(irq), .iack(iack), .iend(iend), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount <= cycleCount + 1;

  // Remember the cycle in which irq was last seen rising.
  always @(negedge CLK) begin
    if (irq === 1'b1 && prevIrq === 1'b0) irqRiseCycle <= cycleCount;
    prevIrq <= irq;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idleCycles(input int n);
    IN_SERIAL_RX = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // One frame: start, 8 data bits LSB first, optional even parity, stop.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    @(negedge CLK);
    lastStartCycle = cycleCount;
    IN_SERIAL_RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      IN_SERIAL_RX = data[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef KBD_PARITY_EN
    IN_SERIAL_RX = (^data) ^ tbParityFlip;
    repeat (CPB) @(negedge CLK);
`endif
    IN_SERIAL_RX = stopBit;
    repeat (CPB) @(negedge CLK);
    IN_SERIAL_RX = 1'b1;
  endtask

  // One iack/iend round; returns what was observed, checks are done by callers.
  task automatic serviceRound(output logic gotIrq, output logic [7:0] kbdSeen,
                              output logic irqAfterAck, output logic irqAfterIend1,
                              output logic irqAfterIend2, output logic ovAfterIend);
    int n;
    n = 0;
    gotIrq = 1'b0; kbdSeen = 8'h00; irqAfterAck = 1'b1;
    irqAfterIend1 = 1'b1; irqAfterIend2 = 1'b1; ovAfterIend = 1'b1;
    while (irq !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    if (irq === 1'b1) begin
      gotIrq = 1'b1;
      iack = 1'b1;
      @(negedge CLK);
      iack = 1'b0;
      kbdSeen = kbd;
      irqAfterAck = irq;
      iend = 1'b1;
      @(negedge CLK);
      iend = 1'b0;
      irqAfterIend1 = irq;
      ovAfterIend = overrun;
      @(negedge CLK);
      irqAfterIend2 = irq;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; IN_SERIAL_RX = 1'b0; iack = 1'b0; iend = 1'b0;
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    compared++;
    if (kbd !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_kbd: got %h required 00", kbd); end
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_irq: got %b required 0", irq); end
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overrun: got %b required 0", overrun); end
  endtask

  // Line low out of reset, short high, then an all-zero frame: only HUNT
  // protection keeps that frame from being taken.
  task automatic test_hunt();
    IN_SERIAL_RX = 1'b0;
    repeat (20) @(negedge CLK);
    idleCycles(4);
    sendFrame(8'h00, 1'b1);
    idleCycles(40);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL hunt_no_push: got irq %b required 0", irq); end
  endtask

  task automatic test_single();
    logic g, a, e1, e2, ov;
    logic [7:0] k;
    sendFrame(8'h5A, 1'b1);
    serviceRound(g, k, a, e1, e2, ov);
    compared++;
    if (g !== 1'b1) begin mismatched++; $display("[TB] FAIL single_irq: got %b required 1", g); end
    compared++;
    if (irqRiseCycle < lastStartCycle + 150 || irqRiseCycle > lastStartCycle + 162) begin
      mismatched++;
      $display("[TB] FAIL single_irq_time: got %0d required %0d..%0d", irqRiseCycle - lastStartCycle, 150, 162);
    end
    compared++;
    if (k !== 8'h5A) begin mismatched++; $display("[TB] FAIL single_kbd: got %h required 5a", k); end
    compared++;
    if (a !== 1'b0) begin mismatched++; $display("[TB] FAIL single_irq_after_ack: got %b required 0", a); end
    compared++;
    if (e1 !== 1'b0 || e2 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_irq_after_iend: got %b%b required 00", e1, e2); end
    repeat (10) @(negedge CLK);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL single_empty: got irq %b required 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic g, a, e1, e2, ov;
    logic [7:0] k;
    logic [7:0] exp [3];
    exp[0] = 8'h31; exp[1] = 8'h32; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) sendFrame(exp[i], 1'b1);
    for (int i = 0; i < 3; i++) begin
      serviceRound(g, k, a, e1, e2, ov);
      compared++;
      if (g !== 1'b1 || k !== exp[i]) begin mismatched++; $display("[TB] FAIL b2b_kbd%0d: got %h required %h", i, k, exp[i]); end
      compared++;
      if (e1 !== 1'b0 || e2 !== (i < 2)) begin
        mismatched++;
        $display("[TB] FAIL b2b_rearm%0d: got %b%b required 0%b", i, e1, e2, (i < 2));
      end
    end
  endtask

  task automatic test_overrun();
    logic g, a, e1, e2, ov;
    logic [7:0] k;
    for (int i = 0; i < 4; i++) sendFrame(8'h41 + 8'(i), 1'b1);
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL overrun_full_no_drop: got %b required 0", overrun); end
    sendFrame(8'h45, 1'b1);
    idleCycles(4);
    compared++;
    if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL overrun_set: got %b required 1", overrun); end
    for (int i = 0; i < 4; i++) begin
      serviceRound(g, k, a, e1, e2, ov);
      compared++;
      if (g !== 1'b1 || k !== 8'h41 + 8'(i)) begin mismatched++; $display("[TB] FAIL overrun_kbd%0d: got %h required %h", i, k, 8'h41 + 8'(i)); end
      if (i == 0) begin
        compared++;
        if (ov !== 1'b0) begin mismatched++; $display("[TB] FAIL overrun_clear: got %b required 0", ov); end
      end
    end
    repeat (10) @(negedge CLK);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL overrun_fifth_dropped: got irq %b required 0", irq); end
  endtask

  task automatic test_glitch();
    logic g, a, e1, e2, ov;
    logic [7:0] k;
    @(negedge CLK);
    IN_SERIAL_RX = 1'b0;
    repeat (4) @(negedge CLK);
    idleCycles(40);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_no_push: got irq %b required 0", irq); end
    iack = 1'b1;
    @(negedge CLK);
    iack = 1'b0;
    @(negedge CLK);
    compared++;
    if (kbd !== 8'h44) begin mismatched++; $display("[TB] FAIL stray_iack_kbd: got %h required 44", kbd); end
    sendFrame(8'h77, 1'b1);
    serviceRound(g, k, a, e1, e2, ov);
    compared++;
    if (g !== 1'b1 || k !== 8'h77) begin mismatched++; $display("[TB] FAIL glitch_next_kbd: got %h required 77", k); end
  endtask

  task automatic test_framing();
    logic g, a, e1, e2, ov;
    logic [7:0] k;
    sendFrame(8'hA5, 1'b0);
    idleCycles(40);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL framing_no_push: got irq %b required 0", irq); end
    sendFrame(8'h12, 1'b1);
    serviceRound(g, k, a, e1, e2, ov);
    compared++;
    if (g !== 1'b1 || k !== 8'h12) begin mismatched++; $display("[TB] FAIL framing_recover_kbd: got %h required 12", k); end
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL framing_overrun: got %b required 0", overrun); end
  endtask

`ifdef KBD_PARITY_EN
  task automatic test_parity();
    logic g, a, e1, e2, ov;
    logic [7:0] k;
    tbParityFlip = 1'b0;
    sendFrame(8'h03, 1'b1);
    serviceRound(g, k, a, e1, e2, ov);
    compared++;
    if (g !== 1'b1 || k !== 8'h03) begin mismatched++; $display("[TB] FAIL parity_good_kbd: got %h required 03", k); end
    tbParityFlip = 1'b1;
    sendFrame(8'h03, 1'b1);
    tbParityFlip = 1'b0;
    idleCycles(40);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL parity_bad_irq: got %b required 0", irq); end
    compared++;
    if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL parity_bad_overrun: got %b required 0", overrun); end
  endtask
`endif

  initial begin
    test_reset();
    test_hunt();
    test_single();
    test_back_to_back();
    test_overrun();
    test_glitch();
    test_framing();
`ifdef KBD_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
